// File: rtl/seq_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pkg
// Brief   : Shared op/state encodings and chunk-count helpers for seq_addsub.
// Revision: 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_addsub_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_addsub_if
// Brief   : Request/response handshake bundle for the sequential add/sub unit.
// Revision: 1.0 - initial release
// ============================================================================
interface seq_addsub_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

endinterface
`default_nettype wire

// File: rtl/seq_addsub_chunk.sv
`default_nettype none
// ============================================================================
// Module  : addsub_chunk
// Brief   : Combinational CHUNK-bit full-adder ripple with top-bit carry tap.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  wire logic [CHUNK-1:0] i_a,
    input  wire logic [CHUNK-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [CHUNK-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_c_msb
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout  = w_carry[CHUNK];
    assign o_c_msb = w_carry[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module  : seq_addsub
// Brief   : Multi-cycle add/sub, CHUNK bits per clock with registered carry.
//           Optional signed saturation: define SEQ_ADDSUB_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_addsub_if.slave bus
);

    localparam int              c_n_chunks = num_chunks(WIDTH, CHUNK);
    localparam int              c_cnt_w    = cnt_width(WIDTH, CHUNK);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_n_chunks - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_c_msb;
    logic               w_cin0;
    logic               w_ovf_final;
    logic [WIDTH-1:0]   w_a_shr;
    logic [WIDTH-1:0]   w_b_shr;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_final;

    // Operands shift right each cycle so the adder always sees bits [CHUNK-1:0].
    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a     (r_a[CHUNK-1:0]),
        .i_b     (r_b[CHUNK-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    if (CHUNK < WIDTH) begin : g_multi
        assign w_a_shr    = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
        assign w_b_shr    = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
        assign w_res_next = {w_sum, r_result[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign w_a_shr    = r_a;
        assign w_b_shr    = r_b;
        assign w_res_next = w_sum;
    end

    always_comb begin
        w_cin0 = 1'b0;
        case (bus.op)
            OP_ADD:  w_cin0 = 1'b0;
            OP_SUB:  w_cin0 = 1'b1;
            OP_ADC:  w_cin0 = bus.cin;
            OP_SBB:  w_cin0 = bus.cin;
            default: w_cin0 = 1'b0;
        endcase
    end

    assign w_ovf_final = w_c_msb ^ w_cout;

`ifdef SEQ_ADDSUB_SAT_EN
    // On overflow both operands share a sign; A's MSB picks the limit.
    always_comb begin
        w_final = w_res_next;
        if (w_ovf_final) begin
            w_final = r_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_final = w_res_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b ^ {WIDTH{bus.op[0]}};
                        r_carry    <= w_cin0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= w_a_shr;
                    r_b     <= w_b_shr;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_result    <= w_final;
                        r_cout      <= w_cout;
                        r_ovf       <= w_ovf_final;
                        r_zero      <= ~|w_final;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_result <= w_res_next;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_addsub
// Brief   : Self-checking bench driving CHUNK=1,2,4,8 instances in lockstep.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_addsub;

    localparam int NDUT = 4;

    logic clk;
    logic rst;
    logic       drv_valid;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic [1:0] drv_op;
    logic       drv_cin;
    logic       drv_ready;

    logic [NDUT-1:0]      t_in_ready;
    logic [NDUT-1:0]      t_out_valid;
    logic [NDUT-1:0]      t_cout;
    logic [NDUT-1:0]      t_ovf;
    logic [NDUT-1:0]      t_zero;
    logic [NDUT-1:0][7:0] t_result;

    int n_cmp = 0;
    int n_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        seq_addsub_if #(.WIDTH(8)) u_if ();

        assign u_if.in_valid  = drv_valid;
        assign u_if.a         = drv_a;
        assign u_if.b         = drv_b;
        assign u_if.op        = drv_op;
        assign u_if.cin       = drv_cin;
        assign u_if.out_ready = drv_ready;

        assign t_in_ready[k]  = u_if.in_ready;
        assign t_out_valid[k] = u_if.out_valid;
        assign t_cout[k]      = u_if.cout;
        assign t_ovf[k]       = u_if.ovf;
        assign t_zero[k]      = u_if.zero;
        assign t_result[k]    = u_if.result;

        seq_addsub #(
            .WIDTH (8),
            .CHUNK (1 << k)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic        cin;
        logic [10:0] exp;  // {cout, ovf, zero, result}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s dut%0d(CHUNK=%0d): got %h want %h", name, k, 1 << k, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operation's meaning.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op, input logic cin);
        int ua, ub, sa, sb, u, s, c_in;
        logic [7:0] r;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op == 2'b00 || op == 2'b10) begin
            c_in = (op == 2'b10) ? int'(cin) : 0;
            u = ua + ub + c_in;
            s = sa + sb + c_in;
            c = (u > 255);
        end else begin
            c_in = (op == 2'b11 && !cin) ? 1 : 0;  // borrow in
            u = ua - ub - c_in;
            s = sa - sb - c_in;
            c = (ua >= ub + c_in);
        end
        r = u[7:0];
        o = (s > 127) || (s < -128);
`ifdef SEQ_ADDSUB_SAT_EN
        if (o) r = (s > 127) ? 8'h7F : 8'h80;
`endif
        return {c, o, (r == 8'h00), r};
    endfunction

    // Accept one op on all instances and wait (bounded) until all show out_valid.
    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                            input logic icin, input logic [10:0] exp, input string name);
        int lat[NDUT];
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check({name, " in_ready"}, k, 32'(t_in_ready[k]), 32'd1);
        drv_a = ia; drv_b = ib; drv_op = iop; drv_cin = icin; drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_a = 8'($urandom); drv_b = 8'($urandom); drv_op = 2'($urandom); drv_cin = 1'($urandom);
        for (int k = 0; k < NDUT; k++) lat[k] = t_out_valid[k] ? 1 : 0;
        for (int e = 2; e <= 14; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) if (t_out_valid[k] && lat[k] == 0) lat[k] = e;
            if (&t_out_valid) break;
        end
        for (int k = 0; k < NDUT; k++) begin
            check({name, " latency"}, k, 32'(lat[k]), 32'(8 / (1 << k) + 1));
            check({name, " result"}, k, {21'd0, t_cout[k], t_ovf[k], t_zero[k], t_result[k]}, {21'd0, exp});
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        drv_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_ready = 1'b0;
        for (int k = 0; k < NDUT; k++)
            check({name, " release"}, k, {30'd0, t_in_ready[k], t_out_valid[k]}, 32'b10);
    endtask

    initial begin
        logic [NDUT-1:0] seen;
        logic [7:0] ra, rb;
        logic [1:0] rop;
        logic       rcin;
        logic [7:0] edge_vals[4];

        vecs[0]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 11'b0};
        vecs[1]  = '{8'h05, 8'h07, 2'b01, 1'b0, {3'b000, 8'hFE}};
        vecs[2]  = '{8'h80, 8'h01, 2'b01, 1'b0, 11'b0};
        vecs[3]  = '{8'hFF, 8'h00, 2'b10, 1'b1, {3'b101, 8'h00}};
        vecs[4]  = '{8'h10, 8'h01, 2'b11, 1'b0, {3'b100, 8'h0E}};
        vecs[5]  = '{8'h00, 8'h00, 2'b00, 1'b1, {3'b001, 8'h00}};
        vecs[6]  = '{8'h33, 8'h33, 2'b01, 1'b0, {3'b101, 8'h00}};
        vecs[7]  = '{8'h80, 8'h80, 2'b00, 1'b0, 11'b0};
        vecs[8]  = '{8'h7F, 8'h00, 2'b10, 1'b1, 11'b0};
        vecs[9]  = '{8'h00, 8'h00, 2'b11, 1'b1, {3'b101, 8'h00}};
        vecs[10] = '{8'h05, 8'h02, 2'b01, 1'b0, {3'b100, 8'h03}};
        vecs[11] = '{8'h01, 8'h01, 2'b00, 1'b1, {3'b000, 8'h02}};
`ifdef SEQ_ADDSUB_SAT_EN
        vecs[0].exp = {3'b010, 8'h7F};
        vecs[2].exp = {3'b110, 8'h80};
        vecs[7].exp = {3'b110, 8'h80};
        vecs[8].exp = {3'b010, 8'h7F};
`else
        vecs[0].exp = {3'b010, 8'h80};
        vecs[2].exp = {3'b110, 8'h7F};
        vecs[7].exp = {3'b111, 8'h00};
        vecs[8].exp = {3'b010, 8'h80};
`endif

        rst = 1'b1;
        drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_op = '0; drv_cin = 1'b0; drv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++)
            check("reset state", k, {19'd0, t_in_ready[k], t_out_valid[k], t_cout[k], t_ovf[k], t_zero[k], t_result[k]},
                  {19'd0, 5'b10000, 8'h00});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].exp, $sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: DONE holds while new requests are presented.
        start_op(8'h05, 8'h07, 2'b01, 1'b0, {3'b000, 8'hFE}, "bp");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drv_valid = 1'b1; drv_a = 8'($urandom); drv_b = 8'($urandom); drv_op = 2'($urandom);
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++)
                check("bp hold", k, {19'd0, t_in_ready[k], t_out_valid[k], t_cout[k], t_ovf[k], t_zero[k], t_result[k]},
                      {19'd0, 5'b01000, 8'hFE});
        end
        drv_valid = 1'b0;
        finish_op("bp");
        start_op(8'h12, 8'h34, 2'b00, 1'b0, {3'b000, 8'h46}, "bp next");
        finish_op("bp next");

        // Reset two edges after acceptance.
        @(negedge clk);
        drv_a = 8'hFF; drv_b = 8'hFF; drv_op = 2'b00; drv_cin = 1'b0; drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        seen = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | t_out_valid;
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("mid reset", k, {19'd0, t_in_ready[k], t_out_valid[k], t_cout[k], t_ovf[k], t_zero[k], t_result[k]},
                  {19'd0, 5'b10000, 8'h00});
            if ((8 >> k) > 2) check("mid reset no valid", k, 32'(seen[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(8'h01, 8'h01, 2'b00, 1'b0, {3'b000, 8'h02}, "after reset");
        finish_op("after reset");

        // Random operands, all ops, against the arithmetic model.
        edge_vals[0] = 8'h00; edge_vals[1] = 8'h7F; edge_vals[2] = 8'h80; edge_vals[3] = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 3)];
            rop = 2'($urandom); rcin = 1'($urandom);
            start_op(ra, rb, rop, rcin, model(ra, rb, rop, rcin), $sformatf("rand%0d", i));
            finish_op($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
